cacheline_burst_adapter: RTL and testbench

Converts single-transaction, full-cacheline requests from the cache datapath's downstream interface into multi-beat bursts on the physical memory bus. On a read, it collects beats into a line. On a write, it splits the writeback line into beats. It sits directly between the cache's downstream address/wdata/rdata ports and main memory, and returns a one-cycle completion response to the cache controller.

---
 rtl/cache_pkg.sv | 19 +
 rtl/cacheline_burst_adapter_if.sv | 38 +++
 rtl/burst_beat_counter.sv | 38 +++
 rtl/cacheline_burst_adapter.sv | 178 +++++++++++++++++
 tb/tb_cacheline_burst_adapter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cacheline burst path.
package cache_pkg;

   localparam int unsigned S_LINE_DEF  = 256;
   localparam int unsigned S_BURST_DEF = 64;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } adapter_state_e;

   // Counter width for 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cacheline_burst_adapter_if.sv
// Cache-side line port plus memory-side burst port of the cacheline burst adapter.
interface cacheline_burst_adapter_if
   import cache_pkg::*;
#(
   parameter int unsigned s_line  = S_LINE_DEF,
   parameter int unsigned s_burst = S_BURST_DEF
);

   logic                line_read_i;
   logic                line_write_i;
   logic [31:0]         line_addr_i;
   logic [s_line-1:0]   line_wdata_i;
   logic [s_line-1:0]   line_rdata_o;
   logic                resp_o;
   logic                err_o;
   logic [31:0]         mem_addr_o;
   logic                mem_read_o;
   logic                mem_write_o;
   logic [s_burst-1:0]  mem_wdata_o;
   logic [s_burst-1:0]  mem_rdata_i;
   logic                mem_resp_i;

   // The adapter is the slave of the cache and drives the memory bus.
   modport slave (
      input  line_read_i, line_write_i, line_addr_i, line_wdata_i,
      input  mem_rdata_i, mem_resp_i,
      output line_rdata_o, resp_o, err_o,
      output mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o
   );

   modport master (
      output line_read_i, line_write_i, line_addr_i, line_wdata_i,
      output mem_rdata_i, mem_resp_i,
      input  line_rdata_o, resp_o, err_o,
      input  mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o
   );

endinterface

// File: rtl/burst_beat_counter.sv
// Beat index counter for burst engines: synchronous clear, increment, last-beat flag.
module burst_beat_counter
   import cache_pkg::*;
#(
   parameter int unsigned NUM_BEATS = S_LINE_DEF / S_BURST_DEF,
   parameter int unsigned CNT_W     = cnt_width(NUM_BEATS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             last_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == CNT_W'(NUM_BEATS - 1));

endmodule

// File: rtl/cacheline_burst_adapter.sv
// Turns one full-line cache read/writeback into num_beats memory bus beats.
// Optional per-beat stall watchdog: define CACHELINE_ADAPTER_TIMEOUT_EN.
module cacheline_burst_adapter
   import cache_pkg::*;
#(
   parameter int unsigned s_line         = S_LINE_DEF,
   parameter int unsigned s_burst        = S_BURST_DEF,
   parameter int unsigned timeout_cycles = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   cacheline_burst_adapter_if.slave bus
);

   localparam int unsigned num_beats = s_line / s_burst;
   localparam int unsigned CntW      = cnt_width(num_beats);

   if ((s_line % s_burst) != 0 || timeout_cycles == 0) begin : g_cfg_check
      $error("cacheline_burst_adapter: s_line must be a multiple of s_burst, timeout_cycles nonzero");
   end

   adapter_state_e                    state_q, state_d;
   logic [31:0]                       addr_q, addr_d;
   logic                              rd_q, rd_d;
   logic                              wr_q, wr_d;
   logic                              resp_q, resp_d;
   logic                              err_q, err_d;
   logic [num_beats-1:0][s_burst-1:0] rbuf_q, rbuf_d;
   logic [num_beats-1:0][s_burst-1:0] wbuf_q, wbuf_d;

   logic [CntW-1:0] cnt;
   logic            cnt_clr;
   logic            cnt_inc;
   logic            cnt_last;
   logic            stall_hit;

   burst_beat_counter #(
      .NUM_BEATS (num_beats),
      .CNT_W     (CntW)
   ) u_beat_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .cnt_o  (cnt),
      .last_o (cnt_last)
   );

`ifdef CACHELINE_ADAPTER_TIMEOUT_EN
   localparam int unsigned StallW = cnt_width(timeout_cycles);

   logic [StallW-1:0] stall_q, stall_d;

   // Counts consecutive beat-less cycles; zero in IDLE so every burst starts fresh.
   always_comb begin
      stall_d = '0;
      if ((state_q == READ || state_q == WRITE) && !bus.mem_resp_i) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_hit = (stall_q == StallW'(timeout_cycles - 1)) && !bus.mem_resp_i;
`else
   assign stall_hit = 1'b0;
`endif

   // Outputs are registered, so each one is computed for the state being entered.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      resp_d  = 1'b0;
      err_d   = 1'b0;
      rbuf_d  = rbuf_q;
      wbuf_d  = wbuf_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.line_write_i) begin
               state_d = WRITE;
               addr_d  = bus.line_addr_i;
               wbuf_d  = bus.line_wdata_i;
               wr_d    = 1'b1;
               cnt_clr = 1'b1;
            end else if (bus.line_read_i) begin
               state_d = READ;
               addr_d  = bus.line_addr_i;
               rd_d    = 1'b1;
               cnt_clr = 1'b1;
            end
         end

         READ: begin
            rd_d = 1'b1;
            if (bus.mem_resp_i) begin
               rbuf_d[cnt] = bus.mem_rdata_i;
               if (cnt_last) begin
                  state_d = DONE;
                  rd_d    = 1'b0;
                  resp_d  = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end else if (stall_hit) begin
               state_d = DONE;
               rd_d    = 1'b0;
               resp_d  = 1'b1;
               err_d   = 1'b1;
            end
         end

         WRITE: begin
            wr_d = 1'b1;
            if (bus.mem_resp_i) begin
               if (cnt_last) begin
                  state_d = DONE;
                  wr_d    = 1'b0;
                  resp_d  = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end else if (stall_hit) begin
               state_d = DONE;
               wr_d    = 1'b0;
               resp_d  = 1'b1;
               err_d   = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
            cnt_clr = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         resp_q  <= 1'b0;
         err_q   <= 1'b0;
         rbuf_q  <= '0;
         wbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         resp_q  <= resp_d;
         err_q   <= err_d;
         rbuf_q  <= rbuf_d;
         wbuf_q  <= wbuf_d;
      end
   end

   assign bus.line_rdata_o = rbuf_q;
   assign bus.resp_o       = resp_q;
   assign bus.err_o        = err_q;
   assign bus.mem_addr_o   = addr_q;
   assign bus.mem_read_o   = rd_q;
   assign bus.mem_write_o  = wr_q;
   assign bus.mem_wdata_o  = wbuf_q[cnt];

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Directed plus randomized bench for cacheline_burst_adapter against a beat-level line model.
module tb_cacheline_burst_adapter;

   localparam int unsigned LW = 256;
   localparam int unsigned BW = 64;
   localparam int unsigned NB = LW / BW;

   logic            clk = 1'b0;
   logic            rst;
   int unsigned     total = 0;
   int unsigned     bad   = 0;
   logic [LW-1:0]   last_rline;
   int unsigned     gap [NB];
   logic [LW-1:0]   wl, rl;
   logic [31:0]     ad;
   bit              wr;
   int unsigned     pulses;

   cacheline_burst_adapter_if #(.s_line(LW), .s_burst(BW)) bus ();

   cacheline_burst_adapter #(
      .s_line         (LW),
      .s_burst        (BW),
      .timeout_cycles (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      check(tag, LW'(obs), LW'(exp));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BW-1:0] beat_of(input logic [LW-1:0] line, input int unsigned b);
      return BW'(line >> (BW * b));
   endfunction

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      l = '0;
      for (int unsigned i = 0; i < LW / 32; i++) l = {l[LW-33:0], $urandom};
      return l;
   endfunction

   task automatic idle_outputs_zero(input string tag);
      chk1({tag, "_read"}, bus.mem_read_o, 1'b0);
      chk1({tag, "_write"}, bus.mem_write_o, 1'b0);
      chk1({tag, "_resp"}, bus.resp_o, 1'b0);
      chk1({tag, "_err"}, bus.err_o, 1'b0);
      check({tag, "_addr"}, LW'(bus.mem_addr_o), '0);
      check({tag, "_rdata"}, bus.line_rdata_o, '0);
      check({tag, "_wdata"}, LW'(bus.mem_wdata_o), '0);
   endtask

   // Present a request for one edge; afterwards the cache's wdata bus is scrambled.
   task automatic request(input bit w, input bit r, input logic [31:0] a, input logic [LW-1:0] line);
      bus.line_write_i = w;
      bus.line_read_i  = r;
      bus.line_addr_i  = a;
      bus.line_wdata_i = line;
      tick();
      bus.line_wdata_i = rand_line();
   endtask

   // Called in the first burst cycle; memory inserts gap[b] idle cycles before beat b.
   task automatic serve(input bit w, input logic [31:0] a, input logic [LW-1:0] wline,
                        input logic [LW-1:0] rline, input int unsigned gp [NB]);
      for (int unsigned b = 0; b < NB; b++) begin
         for (int unsigned g = 0; g <= gp[b]; g++) begin
            bus.mem_resp_i  = (g == gp[b]);
            bus.mem_rdata_i = (g == gp[b]) ? beat_of(rline, b) : {$urandom, $urandom};
            chk1("busy_resp", bus.resp_o, 1'b0);
            chk1("busy_read", bus.mem_read_o, !w);
            chk1("busy_write", bus.mem_write_o, w);
            check("busy_addr", LW'(bus.mem_addr_o), LW'(a));
            if (w) check("wdata_beat", LW'(bus.mem_wdata_o), LW'(beat_of(wline, b)));
            tick();
         end
      end
      bus.mem_resp_i  = 1'b1;
      bus.mem_rdata_i = {$urandom, $urandom};
      chk1("resp_pulse", bus.resp_o, 1'b1);
      chk1("resp_err", bus.err_o, 1'b0);
      chk1("done_read", bus.mem_read_o, 1'b0);
      chk1("done_write", bus.mem_write_o, 1'b0);
      if (!w) last_rline = rline;
      check("rdata_line", bus.line_rdata_o, last_rline);
      if (w) bus.line_write_i = 1'b0;
      else   bus.line_read_i  = 1'b0;
      tick();
      bus.mem_resp_i = 1'b0;
      chk1("resp_single", bus.resp_o, 1'b0);
      check("rdata_hold", bus.line_rdata_o, last_rline);
   endtask

   initial begin
      rst              = 1'b1;
      bus.line_read_i  = 1'b0;
      bus.line_write_i = 1'b0;
      bus.line_addr_i  = '0;
      bus.line_wdata_i = '0;
      bus.mem_rdata_i  = '0;
      bus.mem_resp_i   = 1'b0;
      last_rline       = '0;

      // Reset state, then stray memory responses while idle.
      tick();
      tick();
      idle_outputs_zero("rst");
      rst = 1'b0;
      bus.mem_resp_i  = 1'b1;
      bus.mem_rdata_i = {$urandom, $urandom};
      tick();
      tick();
      bus.mem_resp_i = 1'b0;
      idle_outputs_zero("idle_stray");

      // Fill at 0x1A20 with back-to-back beats.
      rl  = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
      gap = '{0, 0, 0, 0};
      request(1'b0, 1'b1, 32'h0000_1A20, '0);
      serve(1'b0, 32'h0000_1A20, '0, rl, gap);

      // Writeback at 0x400 with two idle cycles before beat 2.
      wl  = {64'hDEAD_3333_3333_3333, 64'h2222_2222_2222_2222,
             64'h1111_1111_1111_1111, 64'h0000_0000_0000_BEEF};
      gap = '{0, 0, 2, 0};
      request(1'b1, 1'b0, 32'h0000_0400, wl);
      serve(1'b1, 32'h0000_0400, wl, '0, gap);

      // Simultaneous requests: writeback first, fill after one idle cycle.
      wl  = rand_line();
      rl  = rand_line();
      gap = '{0, 1, 0, 0};
      request(1'b1, 1'b1, 32'h0000_0800, wl);
      serve(1'b1, 32'h0000_0800, wl, '0, gap);
      chk1("seq_idle_read", bus.mem_read_o, 1'b0);
      tick();
      chk1("seq_read_start", bus.mem_read_o, 1'b1);
      gap = '{0, 0, 0, 0};
      serve(1'b0, 32'h0000_0800, '0, rl, gap);

      // Reset after beat 1 of a fill.
      rl = rand_line();
      request(1'b0, 1'b1, 32'h0000_2000, '0);
      bus.mem_resp_i  = 1'b1;
      bus.mem_rdata_i = beat_of(rl, 0);
      tick();
      bus.mem_rdata_i = beat_of(rl, 1);
      tick();
      bus.mem_resp_i = 1'b0;
      rst = 1'b1;
      #1;
      idle_outputs_zero("rst_mid");
      bus.line_read_i = 1'b0;
      last_rline      = '0;
      tick();
      rst = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         chk1("rst_no_resp", bus.resp_o, 1'b0);
         tick();
      end
      rl  = rand_line();
      gap = '{0, 0, 0, 0};
      request(1'b0, 1'b1, 32'h0000_2000, '0);
      serve(1'b0, 32'h0000_2000, '0, rl, gap);

      // Randomized mix of fills and writebacks.
      for (int unsigned t = 0; t < 8; t++) begin
         wr = ($urandom_range(0, 1) == 1);
         ad = $urandom & 32'hFFFF_FFE0;
         wl = rand_line();
         rl = rand_line();
         for (int unsigned b = 0; b < NB; b++) gap[b] = $urandom_range(0, 2);
         request(wr, !wr, ad, wl);
         serve(wr, ad, wl, rl, gap);
      end

      // Memory never answers a fill.
      request(1'b0, 1'b1, 32'h0000_3000, '0);
      bus.mem_resp_i = 1'b0;
`ifdef CACHELINE_ADAPTER_TIMEOUT_EN
      for (int unsigned i = 0; i < 16; i++) begin
         chk1("to_wait_resp", bus.resp_o, 1'b0);
         tick();
      end
      chk1("to_resp", bus.resp_o, 1'b1);
      chk1("to_err", bus.err_o, 1'b1);
      chk1("to_read_drop", bus.mem_read_o, 1'b0);
      bus.line_read_i = 1'b0;
      tick();
      chk1("to_resp_single", bus.resp_o, 1'b0);
      chk1("to_err_clear", bus.err_o, 1'b0);
`else
      pulses = 0;
      for (int unsigned i = 0; i < 1000; i++) begin
         tick();
         if (bus.resp_o) pulses++;
      end
      check("stall_no_resp", LW'(pulses), '0);
      chk1("stall_still_reading", bus.mem_read_o, 1'b1);
      bus.line_read_i = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("stall_rst_read", bus.mem_read_o, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
